dm: RTL and testbench



---
 rtl/dm_pkg.sv | 12 +
 rtl/dm_if.sv | 26 ++
 rtl/dm_byte_merge.sv | 23 ++
 rtl/dm.sv | 45 ++++
 tb/tb_dm.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the data memory and the datapath around it.
// Optional byte-lane writes are enabled with `define DM_BYTE_WRITE_EN.
package dm_pkg;

    localparam int unsigned DM_DATA_WIDTH = 32;
    localparam int unsigned DM_ADDR_WIDTH = 5;
    localparam int unsigned DM_DEPTH      = 2 ** DM_ADDR_WIDTH;

    typedef logic [DM_DATA_WIDTH-1:0] dm_word_t;
    typedef logic [DM_ADDR_WIDTH-1:0] dm_addr_t;

endpackage

// File: rtl/dm_if.sv
// Data-memory access bus: address, write controls and combinational read data.
// The be lanes exist only when DM_BYTE_WRITE_EN is defined.
interface dm_if
    import dm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DM_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DM_ADDR_WIDTH
);

    logic [ADDR_WIDTH-1:0]   addressDM;
    logic                    we;
    logic [DATA_WIDTH-1:0]   wd;
`ifdef DM_BYTE_WRITE_EN
    logic [DATA_WIDTH/8-1:0] be;
`endif
    logic [DATA_WIDTH-1:0]   rd;

`ifdef DM_BYTE_WRITE_EN
    modport master (output addressDM, output we, output wd, output be, input rd);
    modport slave  (input addressDM, input we, input wd, input be, output rd);
`else
    modport master (output addressDM, output we, output wd, input rd);
    modport slave  (input addressDM, input we, input wd, output rd);
`endif

endinterface

// File: rtl/dm_byte_merge.sv
// Combinational byte-lane merge: each lane takes wd where be is set, else keeps
// the old word. Used by dm only when DM_BYTE_WRITE_EN is defined.
module dm_byte_merge
    import dm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DM_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0]   old_word,
    input  logic [DATA_WIDTH-1:0]   wd,
    input  logic [DATA_WIDTH/8-1:0] be,
    output logic [DATA_WIDTH-1:0]   new_word
);

    always_comb begin
        new_word = old_word;
        for (int unsigned i = 0; i < DATA_WIDTH / 8; i++) begin
            if (be[i]) begin
                new_word[8*i +: 8] = wd[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dm.sv
// Single-port data memory: synchronous word write, asynchronous read, async clear.
// Define DM_BYTE_WRITE_EN to add per-byte write enables (bus.be).
module dm
    import dm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DM_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DM_ADDR_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    dm_if.slave  bus
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] new_word;

`ifdef DM_BYTE_WRITE_EN
    dm_byte_merge #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_byte_merge (
        .old_word (mem[bus.addressDM]),
        .wd       (bus.wd),
        .be       (bus.be),
        .new_word (new_word)
    );
`else
    assign new_word = bus.wd;
`endif

    // Ternary rather than if(we) so an X write enable corrupts the word in simulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i[ADDR_WIDTH-1:0]] <= '0;
            end
        end else begin
            mem[bus.addressDM] <= bus.we ? new_word : mem[bus.addressDM];
        end
    end

    assign bus.rd = mem[bus.addressDM];

endmodule

// File: tb/tb_dm.sv
// Self-checking bench for dm: vector table plus hand-written reset and
// read-during-write sequences, checked through an expected-value queue.
module tb_dm;
    import dm_pkg::*;

    logic clk;
    logic rst_n;

    dm_if bus ();

    dm #(
        .DATA_WIDTH (DM_DATA_WIDTH),
        .ADDR_WIDTH (DM_ADDR_WIDTH)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string    name;
        bit       edge_op;  // 1: hold inputs across a rising edge, then sample
        logic     we;
        dm_addr_t addr;
        dm_word_t wd;
        logic [3:0] be;
        dm_word_t exp;
    } vec_t;

    vec_t     vecs[$];
    dm_word_t exp_q[$];
    string    name_q[$];
    int       checks = 0;
    int       errors = 0;

    task automatic add(input string n, input bit e, input logic w, input dm_addr_t a,
                       input dm_word_t d, input logic [3:0] b, input dm_word_t x);
        vec_t v;
        v.name = n; v.edge_op = e; v.we = w; v.addr = a; v.wd = d; v.be = b; v.exp = x;
        vecs.push_back(v);
    endtask

    task automatic push_exp(input string n, input dm_word_t x);
        name_q.push_back(n);
        exp_q.push_back(x);
    endtask

    task automatic pop_check();
        dm_word_t x;
        string    n;
        x = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (bus.rd !== x) begin
            errors++;
            $display("FAIL %s: rd=%h expected %h", n, bus.rd, x);
        end
    endtask

    task automatic drive(input logic w, input dm_addr_t a, input dm_word_t d, input logic [3:0] b);
        bus.we = w;
        bus.addressDM = a;
        bus.wd = d;
`ifdef DM_BYTE_WRITE_EN
        bus.be = b;
`else
        if (b != 4'hF) $display("note: be=%h ignored in full-word build", b);
`endif
    endtask

    task automatic read_at(input string n, input dm_addr_t a, input dm_word_t x);
        @(negedge clk);
        drive(1'b0, a, '0, 4'hF);
        push_exp(n, x);
        #1;
        pop_check();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b0, '0, '0, 4'hF);

        // Reset sweep: every address reads zero while held in reset
        for (int a = 0; a < int'(DM_DEPTH); a++) begin
            read_at("reset_sweep", dm_addr_t'(a), '0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        read_at("after_release_a5", 5'd5, '0);

        add("wr_a0",        1, 1, 5'd0,  32'hAAAA_AAAA, 4'hF, 32'hAAAA_AAAA);
        add("wr_a1",        1, 1, 5'd1,  32'hBBBB_BBBB, 4'hF, 32'hBBBB_BBBB);
        add("rd_a0",        0, 0, 5'd0,  32'h0,         4'hF, 32'hAAAA_AAAA);
        add("rd_a1",        0, 0, 5'd1,  32'h0,         4'hF, 32'hBBBB_BBBB);
        add("wr_a2",        1, 1, 5'd2,  32'hCCCC_CCCC, 4'hF, 32'hCCCC_CCCC);
        add("rd_a2",        0, 0, 5'd2,  32'h0,         4'hF, 32'hCCCC_CCCC);
        add("iso_a0",       0, 0, 5'd0,  32'h0,         4'hF, 32'hAAAA_AAAA);
        add("iso_a1",       0, 0, 5'd1,  32'h0,         4'hF, 32'hBBBB_BBBB);
        add("iso_a31",      0, 0, 5'd31, 32'h0,         4'hF, 32'h0);
        add("we0_edge1",    1, 0, 5'd0,  32'hDEAD_BEEF, 4'hF, 32'hAAAA_AAAA);
        add("we0_edge2",    1, 0, 5'd0,  32'hDEAD_BEEF, 4'hF, 32'hAAAA_AAAA);
        add("we0_edge3",    1, 0, 5'd0,  32'hDEAD_BEEF, 4'hF, 32'hAAAA_AAAA);
        add("wr_a31",       1, 1, 5'd31, 32'h3131_3131, 4'hF, 32'h3131_3131);
        add("rd_a30",       0, 0, 5'd30, 32'h0,         4'hF, 32'h0);
`ifdef DM_BYTE_WRITE_EN
        add("wr_a3_full",   1, 1, 5'd3,  32'h1122_3344, 4'hF, 32'h1122_3344);
        add("wr_a3_be0101", 1, 1, 5'd3,  32'hFFFF_FFFF, 4'h5, 32'h11FF_33FF);
        add("wr_a3_be0000", 1, 1, 5'd3,  32'h0000_0000, 4'h0, 32'h11FF_33FF);
        add("wr_a3_be1000", 1, 1, 5'd3,  32'hAB00_0000, 4'h8, 32'hABFF_33FF);
`else
        add("wr_a3_full",   1, 1, 5'd3,  32'h1122_3344, 4'hF, 32'h1122_3344);
        add("wr_a3_over",   1, 1, 5'd3,  32'hFFFF_FFFF, 4'hF, 32'hFFFF_FFFF);
`endif
        add("rd_a2_again",  0, 0, 5'd2,  32'h0,         4'hF, 32'hCCCC_CCCC);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].be);
            push_exp(vecs[i].name, vecs[i].exp);
            if (vecs[i].edge_op) begin
                @(posedge clk);
            end
            #1;
            pop_check();
            bus.we = 1'b0;
        end

        // Read-during-write: old contents before the edge, new data after it
        @(negedge clk);
        drive(1'b1, 5'd4, 32'h1234_5678, 4'hF);
        push_exp("rdw_before", 32'h0);
        #1;
        pop_check();
        push_exp("rdw_after", 32'h1234_5678);
        @(posedge clk);
        #1;
        pop_check();
        bus.we = 1'b0;

        // Asynchronous reset between edges, then a write that overlaps reset
        @(negedge clk);
        drive(1'b0, 5'd0, '0, 4'hF);
        push_exp("pre_reset_a0", 32'hAAAA_AAAA);
        #1;
        pop_check();
        #1;
        rst_n = 1'b0;
        push_exp("async_clear_a0", 32'h0);
        #1;
        pop_check();
        drive(1'b1, 5'd0, 32'h5555_5555, 4'hF);
        push_exp("write_in_reset", 32'h0);
        @(posedge clk);
        #1;
        pop_check();
        @(negedge clk);
        bus.we = 1'b0;
        rst_n = 1'b1;
        read_at("post_reset_a0", 5'd0, '0);
        read_at("post_reset_a1", 5'd1, '0);
        read_at("post_reset_a2", 5'd2, '0);
        read_at("post_reset_a4", 5'd4, '0);

        // First edge after release accepts a write
        @(negedge clk);
        drive(1'b1, 5'd7, 32'h7777_0007, 4'hF);
        push_exp("first_write_after_reset", 32'h7777_0007);
        @(posedge clk);
        #1;
        pop_check();
        bus.we = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
